// File: rtl/ahbl_dmac_regs.sv
// AHB-Lite slave register file that programs and monitors the dmac_master DMA engine.
// Optional feature macro: DMAC_REGS_IRQ_EN adds the IM register and the registered done interrupt.
module ahbl_dmac_regs (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] saddr,
    output logic [31:0] daddr,
    output logic [31:0] icra,
    output logic [31:0] icrv,
    output logic [2:0]  ssize,
    output logic [2:0]  dsize,
    output logic [2:0]  sinc,
    output logic [2:0]  dinc,
    output logic [7:0]  bsize,
    output logic [7:0]  bcount,
    output logic        wfi,
    output logic [2:0]  irqsrc,
    output logic        start,
    input  logic        busy,
    input  logic        done,
    output logic        irq
);

    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    lane_enables = 4'b0001 << lsb;
            3'd1:    lane_enables = lsb[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_enables = 4'b1111;
            default: lane_enables = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merge_lanes = (old_v & ~mask) | (new_v & mask);
    endfunction

    logic        valid_r, write_r, start_r, done_r, wfi_r;
    logic [3:0]  addr_r;
    logic [2:0]  size_r, ssize_r, dsize_r, sinc_r, dinc_r, irqsrc_r;
    logic [1:0]  lsb_r;
    logic [31:0] saddr_r, daddr_r, icra_r, icrv_r;
    logic [7:0]  bsize_r, bcount_r;

    logic [3:0]  be_s;
    logic        wr_s, wr_lock_s, clr_s;
    logic [31:0] cfg_rd_s, blk_rd_s, ctrl_rd_s, status_rd_s, im_rd_s, rdata_s;
    logic [31:0] cfg_wr_s, blk_wr_s, ctrl_wr_s;

    assign be_s        = lane_enables(size_r, lsb_r);
    assign wr_s        = valid_r & write_r;
    assign wr_lock_s   = wr_s & ~busy;
    assign clr_s       = wr_s & (addr_r == 4'h7) & be_s[0] & HWDATA[1];
    assign cfg_rd_s    = {17'd0, dinc_r, 1'b0, sinc_r, 1'b0, dsize_r, 1'b0, ssize_r};
    assign blk_rd_s    = {16'd0, bcount_r, bsize_r};
    assign ctrl_rd_s   = {25'd0, irqsrc_r, 2'b00, wfi_r, 1'b0};
    assign status_rd_s = {30'd0, done_r, busy};
    assign cfg_wr_s    = merge_lanes(cfg_rd_s, HWDATA, be_s);
    assign blk_wr_s    = merge_lanes(blk_rd_s, HWDATA, be_s);
    assign ctrl_wr_s   = merge_lanes(ctrl_rd_s, HWDATA, be_s);

    logic unused_s;
    assign unused_s = ^{HADDR[31:6], HTRANS[0], cfg_wr_s[31:15], cfg_wr_s[11], cfg_wr_s[7],
                        cfg_wr_s[3], blk_wr_s[31:16], ctrl_wr_s[31:7], ctrl_wr_s[3:2], ctrl_wr_s[0]};

    // Address-phase capture, locked register writes, start pulse and sticky DONE flag
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            valid_r  <= 1'b0;
            write_r  <= 1'b0;
            addr_r   <= 4'h0;
            size_r   <= 3'd0;
            lsb_r    <= 2'd0;
            start_r  <= 1'b0;
            done_r   <= 1'b0;
            saddr_r  <= 32'd0;
            daddr_r  <= 32'd0;
            icra_r   <= 32'd0;
            icrv_r   <= 32'd0;
            ssize_r  <= 3'd2;
            dsize_r  <= 3'd2;
            sinc_r   <= 3'd4;
            dinc_r   <= 3'd4;
            bsize_r  <= 8'd0;
            bcount_r <= 8'd0;
            wfi_r    <= 1'b0;
            irqsrc_r <= 3'd0;
        end else begin
            valid_r <= HSEL & HTRANS[1] & HREADY;
            if (HSEL & HTRANS[1] & HREADY) begin
                write_r <= HWRITE;
                addr_r  <= HADDR[5:2];
                size_r  <= HSIZE;
                lsb_r   <= HADDR[1:0];
            end
            start_r <= wr_lock_s & (addr_r == 4'h4) & be_s[0] & HWDATA[0];
            // A done pulse in the same cycle as the W1C keeps the flag set
            done_r  <= done | (done_r & ~clr_s);
            if (wr_lock_s) begin
                case (addr_r)
                    4'h0: saddr_r <= merge_lanes(saddr_r, HWDATA, be_s);
                    4'h1: daddr_r <= merge_lanes(daddr_r, HWDATA, be_s);
                    4'h2: begin
                        ssize_r <= cfg_wr_s[2:0];
                        dsize_r <= cfg_wr_s[6:4];
                        sinc_r  <= cfg_wr_s[10:8];
                        dinc_r  <= cfg_wr_s[14:12];
                    end
                    4'h3: begin
                        bsize_r  <= blk_wr_s[7:0];
                        bcount_r <= blk_wr_s[15:8];
                    end
                    4'h4: begin
                        wfi_r    <= ctrl_wr_s[1];
                        irqsrc_r <= ctrl_wr_s[6:4];
                    end
                    4'h5: icra_r <= merge_lanes(icra_r, HWDATA, be_s);
                    4'h6: icrv_r <= merge_lanes(icrv_r, HWDATA, be_s);
                    default: ;
                endcase
            end
        end
    end

`ifdef DMAC_REGS_IRQ_EN
    logic        im_r, irq_r;
    logic [31:0] im_wr_s;
    logic        unused_im_s;
    assign im_wr_s     = merge_lanes({31'd0, im_r}, HWDATA, be_s);
    assign unused_im_s = ^im_wr_s[31:1];
    assign im_rd_s     = {31'd0, im_r};
    assign irq         = irq_r;

    // Interrupt mask register and registered done interrupt
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            im_r  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (wr_s && (addr_r == 4'h8)) begin
                im_r <= im_wr_s[0];
            end
            irq_r <= done_r & im_r;
        end
    end
`else
    assign im_rd_s = 32'd0;
    assign irq     = 1'b0;
`endif

    // Read mux from the registered address and current register state
    always_comb begin
        rdata_s = 32'd0;
        case (addr_r)
            4'h0:    rdata_s = saddr_r;
            4'h1:    rdata_s = daddr_r;
            4'h2:    rdata_s = cfg_rd_s;
            4'h3:    rdata_s = blk_rd_s;
            4'h4:    rdata_s = ctrl_rd_s;
            4'h5:    rdata_s = icra_r;
            4'h6:    rdata_s = icrv_r;
            4'h7:    rdata_s = status_rd_s;
            4'h8:    rdata_s = im_rd_s;
            default: rdata_s = 32'd0;
        endcase
        if (valid_r && !write_r) begin
            HRDATA = rdata_s;
        end else begin
            HRDATA = 32'd0;
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign saddr     = saddr_r;
    assign daddr     = daddr_r;
    assign icra      = icra_r;
    assign icrv      = icrv_r;
    assign ssize     = ssize_r;
    assign dsize     = dsize_r;
    assign sinc      = sinc_r;
    assign dinc      = dinc_r;
    assign bsize     = bsize_r;
    assign bcount    = bcount_r;
    assign wfi       = wfi_r;
    assign irqsrc    = irqsrc_r;
    assign start     = start_r;

endmodule

// File: tb/tb_ahbl_dmac_regs.sv
// Directed self-checking bench for ahbl_dmac_regs; follows DMAC_REGS_IRQ_EN when defined.
module tb_ahbl_dmac_regs;

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, HREADY, busy, done;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADYOUT, HRESP, start, wfi, irq;
    logic [31:0] HRDATA, saddr, daddr, icra, icrv;
    logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
    logic [7:0]  bsize, bcount;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    ahbl_dmac_regs dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .saddr(saddr), .daddr(daddr), .icra(icra), .icrv(icrv),
        .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc),
        .bsize(bsize), .bcount(bcount), .wfi(wfi), .irqsrc(irqsrc),
        .start(start), .busy(busy), .done(done), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz, input logic wr);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HSIZE = sz; HWRITE = wr;
    endtask

    task automatic idle_phase();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        addr_phase(a, sz, 1'b1);
        @(posedge HCLK); #1;
        idle_phase(); HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr_phase(a, 3'd2, 1'b0);
        @(posedge HCLK); #1;
        idle_phase();
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++;
            $display("FAIL reset_resp got %b/%b exp 1/0", HREADYOUT, HRESP); end
        HRESET = 1'b0;
        checks++; if (start !== 1'b0 || irq !== 1'b0 || HRDATA !== 32'd0) begin errors++;
            $display("FAIL reset_outs got start=%b irq=%b rdata=%h exp 0", start, irq, HRDATA); end
        bus_rd(32'h08, rd);
        checks++; if (rd !== 32'h0000_4422) begin errors++;
            $display("FAIL reset_cfg got %h exp 00004422", rd); end
        bus_rd(32'h00, rd);
        checks++; if (rd !== 32'd0) begin errors++;
            $display("FAIL reset_saddr got %h exp 00000000", rd); end
    endtask

    task automatic test_write_lanes();
        bus_wr(32'h00, 3'd2, 32'h2000_0010);
        bus_wr(32'h05, 3'd0, 32'h0000_AB00);
        checks++; if (saddr !== 32'h2000_0010 || daddr !== 32'h0000_AB00) begin errors++;
            $display("FAIL lanes_out got %h %h exp 20000010 0000ab00", saddr, daddr); end
        bus_rd(32'h04, rd);
        checks++; if (rd !== 32'h0000_AB00) begin errors++;
            $display("FAIL lanes_rd_daddr got %h exp 0000ab00", rd); end
        bus_wr(32'h0C, 3'd1, 32'hFFFF_0506);
        checks++; if (bsize !== 8'h06 || bcount !== 8'h05) begin errors++;
            $display("FAIL half_blk got %h %h exp 06 05", bsize, bcount); end
        bus_wr(32'h16, 3'd1, 32'hBEEF_1111);
        checks++; if (icra !== 32'hBEEF_0000) begin errors++;
            $display("FAIL half_icra got %h exp beef0000", icra); end
        bus_wr(32'h24, 3'd2, 32'h1234_5678);
        bus_rd(32'h24, rd);
        checks++; if (rd !== 32'd0) begin errors++;
            $display("FAIL unmapped got %h exp 00000000", rd); end
    endtask

    task automatic test_back_to_back();
        addr_phase(32'h18, 3'd2, 1'b1);
        @(posedge HCLK); #1;
        HWDATA = 32'hCAFE_F00D;
        addr_phase(32'h18, 3'd2, 1'b0);
        @(posedge HCLK); #1;
        idle_phase();
        checks++; if (HRDATA !== 32'hCAFE_F00D || icrv !== 32'hCAFE_F00D || HREADYOUT !== 1'b1) begin errors++;
            $display("FAIL b2b_rd got %h %h rdy=%b exp cafef00d", HRDATA, icrv, HREADYOUT); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_start();
        busy = 1'b0;
        addr_phase(32'h10, 3'd2, 1'b1);
        @(posedge HCLK); #1;
        idle_phase(); HWDATA = 32'h53;
        checks++; if (start !== 1'b0) begin errors++;
            $display("FAIL start_early got %b exp 0", start); end
        @(posedge HCLK); #1;
        checks++; if (start !== 1'b1 || wfi !== 1'b1 || irqsrc !== 3'd5) begin errors++;
            $display("FAIL start_pulse got start=%b wfi=%b irqsrc=%0d exp 1 1 5", start, wfi, irqsrc); end
        @(posedge HCLK); #1;
        checks++; if (start !== 1'b0) begin errors++;
            $display("FAIL start_width got %b exp 0", start); end
        bus_rd(32'h10, rd);
        checks++; if (rd !== 32'h52) begin errors++;
            $display("FAIL ctrl_rd got %h exp 00000052", rd); end
    endtask

    task automatic test_lock();
        busy = 1'b1;
        bus_wr(32'h00, 3'd2, 32'hFFFF_FFFF);
        checks++; if (saddr !== 32'h2000_0010) begin errors++;
            $display("FAIL lock_saddr got %h exp 20000010", saddr); end
        bus_wr(32'h10, 3'd2, 32'h1);
        checks++; if (start !== 1'b0 || wfi !== 1'b1 || irqsrc !== 3'd5) begin errors++;
            $display("FAIL lock_ctrl got start=%b wfi=%b irqsrc=%0d exp 0 1 5", start, wfi, irqsrc); end
        bus_rd(32'h1C, rd);
        checks++; if (rd !== 32'h1) begin errors++;
            $display("FAIL lock_status got %h exp 00000001", rd); end
        busy = 1'b0;
    endtask

    task automatic test_done_irq();
        logic exp_irq;
`ifdef DMAC_REGS_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        bus_wr(32'h20, 3'd2, 32'h1);
        bus_rd(32'h20, rd);
        checks++; if (rd !== {31'd0, exp_irq}) begin errors++;
            $display("FAIL im_rd got %h exp %h", rd, {31'd0, exp_irq}); end
        done = 1'b1;
        @(posedge HCLK); #1;
        done = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL irq_early got %b exp 0", irq); end
        @(posedge HCLK); #1;
        checks++; if (irq !== exp_irq) begin errors++;
            $display("FAIL irq_rise got %b exp %b", irq, exp_irq); end
        bus_rd(32'h1C, rd);
        checks++; if (rd !== 32'h2) begin errors++;
            $display("FAIL done_set got %h exp 00000002", rd); end
        addr_phase(32'h1C, 3'd2, 1'b1);
        @(posedge HCLK); #1;
        idle_phase(); HWDATA = 32'h2; done = 1'b1;
        @(posedge HCLK); #1;
        done = 1'b0;
        bus_rd(32'h1C, rd);
        checks++; if (rd !== 32'h2) begin errors++;
            $display("FAIL set_wins got %h exp 00000002", rd); end
        bus_wr(32'h1C, 3'd2, 32'h2);
        @(posedge HCLK); #1;
        checks++; if (irq !== 1'b0) begin errors++;
            $display("FAIL irq_clear got %b exp 0", irq); end
        bus_rd(32'h1C, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL done_w1c got %h exp 00000000", rd); end
    endtask

    task automatic test_reset_mid();
        done = 1'b1;
        @(posedge HCLK); #1;
        done = 1'b0;
        addr_phase(32'h10, 3'd2, 1'b1);
        @(posedge HCLK); #1;
        idle_phase(); HWDATA = 32'h1; HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        checks++; if (start !== 1'b0) begin errors++;
            $display("FAIL rst_start got %b exp 0", start); end
        checks++; if (saddr !== 32'd0 || daddr !== 32'd0 || icra !== 32'd0 || icrv !== 32'd0 ||
                      bsize !== 8'd0 || bcount !== 8'd0 || wfi !== 1'b0 || irqsrc !== 3'd0 ||
                      ssize !== 3'd2 || dsize !== 3'd2 || sinc !== 3'd4 || dinc !== 3'd4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_regs got saddr=%h daddr=%h icra=%h icrv=%h blk=%h/%h wfi=%b src=%0d cfg=%0d%0d%0d%0d irq=%b",
                     saddr, daddr, icra, icrv, bcount, bsize, wfi, irqsrc, dinc, sinc, dsize, ssize, irq);
        end
        @(posedge HCLK); #1;
        checks++; if (start !== 1'b0) begin errors++;
            $display("FAIL rst_start_late got %b exp 0", start); end
        bus_rd(32'h1C, rd);
        checks++; if (rd !== 32'd0) begin errors++;
            $display("FAIL rst_status got %h exp 00000000", rd); end
        bus_rd(32'h20, rd);
        checks++; if (rd !== 32'd0) begin errors++;
            $display("FAIL rst_im got %h exp 00000000", rd); end
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0; HSIZE = 3'd2;
        HWRITE = 1'b0; HWDATA = 32'd0; HREADY = 1'b1; busy = 1'b0; done = 1'b0;
        test_reset();
        test_write_lanes();
        test_back_to_back();
        test_start();
        test_lock();
        test_done_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
